// File: rtl/ifq_superscalar.sv
// Instruction fetch queue: buffers line-aligned i_cache fetches and presents up to
// ISSUE_WIDTH sequential instructions per cycle, re-steering on jump/branch redirect.
module ifq_superscalar #(
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    CACHE_LINE_WIDTH = 128,
    parameter int                    FIFO_DEPTH       = 4,
    parameter int                    ISSUE_WIDTH      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC         = 32'h00400000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CACHE_LINE_WIDTH-1:0]        D_out,
    input  logic                               d_out_valid,
    input  logic [ISSUE_WIDTH-1:0]             rd_en,
    input  logic [DATA_WIDTH-1:0]              Jmp_branch_address,
    input  logic                               jmp_branch_valid,
    output logic [DATA_WIDTH-1:0]              PC_in,
    output logic                               rd_en_o,
    output logic                               abort,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  Instr,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  PC_out,
    output logic [ISSUE_WIDTH-1:0]             instr_valid,
    output logic                               empty
);

    localparam int W      = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int OFF_W  = $clog2(W);
    localparam int POS_W  = OFF_W + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int KW     = $clog2(ISSUE_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] LINE_BYTES = DATA_WIDTH'(CACHE_LINE_WIDTH / 8);
    localparam logic [DATA_WIDTH-1:0] LINE_MASK  = ~(LINE_BYTES - DATA_WIDTH'(1));

    logic [CACHE_LINE_WIDTH-1:0] line_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]       pc_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0]      rd_ptr, wr_ptr, next_ptr;
    logic [CNT_W-1:0]      count;
    logic [OFF_W-1:0]      off;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic                  full, push, pop;
    logic [ISSUE_WIDTH-1:0] slot_valid;
    logic [KW-1:0]         consume_cnt;
    logic [POS_W-1:0]      off_next_ext;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign rd_en_o  = rst & ~full & ~jmp_branch_valid;
    assign abort    = rst & jmp_branch_valid;
    assign PC_in    = fetch_pc;
    assign push     = rd_en_o & d_out_valid;
    assign next_ptr = rd_ptr + PTR_W'(1);

    // Slot k reads word (off+k); the carry bit of that sum selects the line after the head.
    always_comb begin
        logic [POS_W-1:0]            pos;
        logic [CACHE_LINE_WIDTH-1:0] src;
        Instr      = '0;
        PC_out     = '0;
        slot_valid = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            pos = {1'b0, off} + POS_W'(k);
            src = pos[OFF_W] ? line_mem[next_ptr] : line_mem[rd_ptr];
            if (count > CNT_W'(pos[OFF_W])) begin
                slot_valid[k] = 1'b1;
                Instr[k*DATA_WIDTH +: DATA_WIDTH]  = src[pos[OFF_W-1:0]*DATA_WIDTH +: DATA_WIDTH];
                PC_out[k*DATA_WIDTH +: DATA_WIDTH] = pc_mem[rd_ptr] + DATA_WIDTH'({pos, 2'b00});
            end
        end
    end

    assign instr_valid = slot_valid;

    always_comb begin
        consume_cnt = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (rd_en[k] & slot_valid[k]) begin
                consume_cnt = consume_cnt + KW'(1);
            end
        end
    end

    assign off_next_ext = {1'b0, off} + POS_W'(consume_cnt);
    assign pop          = ~jmp_branch_valid & off_next_ext[OFF_W];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            off      <= '0;
            fetch_pc <= RESET_PC;
        end else if (jmp_branch_valid) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            off      <= OFF_W'(Jmp_branch_address >> 2);
            fetch_pc <= Jmp_branch_address & LINE_MASK;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + LINE_BYTES;
            end
            if (pop) begin
                rd_ptr <= next_ptr;
            end
            off   <= off_next_ext[OFF_W-1:0];
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: line storage has no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            line_mem[wr_ptr] <= D_out;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_ifq_superscalar.sv
// Bench for ifq_superscalar: zero-wait i_cache model, instruction-stream reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_ifq_superscalar;

    localparam logic [31:0] RESET_PC = 32'h00400000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] d_out;
    logic         d_out_valid;
    logic [1:0]   rd_en = 2'b00;
    logic [31:0]  jmp_addr = 32'h0;
    logic         jmp = 1'b0;
    logic         stall = 1'b0;
    logic [31:0]  pc_in;
    logic         rd_en_o, abort, empty;
    logic [63:0]  instr, pc_out;
    logic [1:0]   instr_valid;

    int checks = 0;
    int errors = 0;

    ifq_superscalar dut (
        .clk                (clk),
        .rst                (rst),
        .D_out              (d_out),
        .d_out_valid        (d_out_valid),
        .rd_en              (rd_en),
        .Jmp_branch_address (jmp_addr),
        .jmp_branch_valid   (jmp),
        .PC_in              (pc_in),
        .rd_en_o            (rd_en_o),
        .abort              (abort),
        .Instr              (instr),
        .PC_out             (pc_out),
        .instr_valid        (instr_valid),
        .empty              (empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_5A5A;
    endfunction

    // Zero-wait cache: every word of the requested line is derived from its own address.
    always_comb begin
        d_out = '0;
        for (int i = 0; i < 4; i++) d_out[i*32 +: 32] = instr_of(pc_in + 32'(4 * i));
    end
    assign d_out_valid = ~stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a window of the instruction stream starting at m_head,
    // backed by a list of consecutive buffered line addresses.
    logic [31:0] m_lines[$];
    logic [31:0] m_head  = RESET_PC;
    logic [31:0] m_fetch = RESET_PC;

    function automatic bit m_valid(input int k);
        logic [31:0] pc;
        pc = m_head + 32'(4 * k);
        if (!rst || m_lines.size() == 0) return 1'b0;
        return ((pc >> 4) - (m_lines[0] >> 4)) < 32'(m_lines.size());
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lines.delete();
            m_head  = RESET_PC;
            m_fetch = RESET_PC;
        end else if (jmp) begin
            m_lines.delete();
            m_head  = jmp_addr & ~32'h3;
            m_fetch = jmp_addr & ~32'hF;
        end else begin
            int  k;
            bit  do_push;
            k = 0;
            do_push = (m_lines.size() < 4) && !stall;
            for (int i = 0; i < 2; i++) if (rd_en[i] && m_valid(i)) k++;
            m_head = m_head + 32'(4 * k);
            while (m_lines.size() > 0 && (m_head >> 4) > (m_lines[0] >> 4)) void'(m_lines.pop_front());
            if (do_push) begin
                m_lines.push_back(m_fetch);
                m_fetch = m_fetch + 32'd16;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit          v;
            logic [31:0] p;
            v = m_valid(k);
            p = m_head + 32'(4 * k);
            check("model instr_valid", 64'(instr_valid[k]), 64'(v));
            check("model PC_out", 64'(pc_out[k*32 +: 32]), v ? 64'(p) : 64'd0);
            check("model Instr", 64'(instr[k*32 +: 32]), v ? 64'(instr_of(p)) : 64'd0);
        end
        check("model rd_en_o", 64'(rd_en_o), 64'(rst && m_lines.size() < 4 && !jmp));
        check("model abort", 64'(abort), 64'(rst && jmp));
        check("model empty", 64'(empty), 64'(m_lines.size() == 0));
        check("model PC_in", 64'(pc_in), 64'(m_fetch));
    end

    always @(negedge clk) begin
        assert (rd_en != 2'b10) else $error("rd_en is not a thermometer code");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_pc [4] = '{32'h00400000, 32'h00400008, 32'h00400010, 32'h00400018};
    logic        t2_ro [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // 1: reset release, queue fills to full
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t1 first PC_in", 64'(pc_in), 64'h00400000);
        check("t1 first rd_en_o", 64'(rd_en_o), 64'h1);
        check("t1 empty before fill", 64'(empty), 64'h1);
        repeat (4) tick();
        @(negedge clk);
        check("t1 rd_en_o full", 64'(rd_en_o), 64'h0);
        check("t1 empty full", 64'(empty), 64'h0);
        check("t1 PC_in full", 64'(pc_in), 64'h00400040);
        check("t1 PC_out", pc_out, 64'h00400004_00400000);
        check("t1 Instr slot0", 64'(instr[31:0]), 64'hA5E55A5A);

        // 2: dual consume, pop every second cycle
        tick();
        rd_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2 PC_out[0]", 64'(pc_out[31:0]), 64'(t2_pc[i]));
            check("t2 PC_out[1]", 64'(pc_out[63:32]), 64'(t2_pc[i] + 32'd4));
            check("t2 rd_en_o", 64'(rd_en_o), 64'(t2_ro[i]));
            tick();
        end
        repeat (6) tick();

        // 3: redirect into the middle of a line while consuming and fetching
        jmp = 1'b1;
        jmp_addr = 32'h004000b8;
        @(negedge clk);
        check("t3 abort", 64'(abort), 64'h1);
        check("t3 rd_en_o during redirect", 64'(rd_en_o), 64'h0);
        tick();
        jmp = 1'b0;
        @(negedge clk);
        check("t3 abort one cycle", 64'(abort), 64'h0);
        check("t3 empty after redirect", 64'(empty), 64'h1);
        check("t3 PC_in target line", 64'(pc_in), 64'h004000b0);
        tick();
        @(negedge clk);
        check("t3 valid b8", 64'(instr_valid), 64'h3);
        check("t3 PC_out b8/bc", pc_out, 64'h004000bc_004000b8);
        tick();
        @(negedge clk);
        check("t3 PC_out c0/c4", pc_out, 64'h004000c4_004000c0);

        // 4: redirect to the last word of a line, next line delayed by cache misses
        tick();
        jmp = 1'b1;
        jmp_addr = 32'h004000cc;
        rd_en = 2'b00;
        tick();
        jmp = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4 single slot", 64'(instr_valid), 64'h1);
            check("t4 PC_out", pc_out, 64'h00000000_004000cc);
            check("t4 PC_in held", 64'(pc_in), 64'h004000d0);
            tick();
        end
        stall = 1'b0;
        tick();
        @(negedge clk);
        check("t4 both slots", 64'(instr_valid), 64'h3);
        check("t4 PC_out cc/d0", pc_out, 64'h004000d0_004000cc);
        check("t4 Instr slot1", 64'(instr[63:32]), 64'hA5E55A8A);

        // 5: redirect, consume and cache hit in the same cycle; then back-to-back redirects
        tick();
        rd_en = 2'b11;
        repeat (3) tick();
        jmp = 1'b1;
        jmp_addr = 32'h00400105;
        @(negedge clk);
        check("t5 abort", 64'(abort), 64'h1);
        check("t5 rd_en_o", 64'(rd_en_o), 64'h0);
        tick();
        jmp = 1'b0;
        rd_en = 2'b00;
        @(negedge clk);
        check("t5 flushed", 64'(empty), 64'h1);
        check("t5 PC_in", 64'(pc_in), 64'h00400100);
        check("t5 no slots", 64'(instr_valid), 64'h0);
        tick();
        @(negedge clk);
        check("t5 PC_out 104/108", pc_out, 64'h00400108_00400104);
        tick();
        jmp = 1'b1;
        jmp_addr = 32'h00400200;
        tick();
        jmp_addr = 32'h00400034;
        tick();
        jmp = 1'b0;
        @(negedge clk);
        check("t5 last redirect wins", 64'(pc_in), 64'h00400030);
        tick();
        @(negedge clk);
        check("t5 PC_out 34/38", pc_out, 64'h00400038_00400034);

        // 6: asynchronous reset mid-stream
        tick();
        rd_en = 2'b11;
        repeat (3) tick();
        @(posedge clk);
        #3 rst = 1'b0;
        jmp = 1'b1;
        #1;
        check("t6 empty in reset", 64'(empty), 64'h1);
        check("t6 rd_en_o in reset", 64'(rd_en_o), 64'h0);
        check("t6 abort in reset", 64'(abort), 64'h0);
        check("t6 instr_valid in reset", 64'(instr_valid), 64'h0);
        check("t6 Instr in reset", instr, 64'h0);
        jmp = 1'b0;
        rd_en = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6 PC_in after release", 64'(pc_in), 64'h00400000);
        check("t6 rd_en_o after release", 64'(rd_en_o), 64'h1);
        repeat (4) tick();
        @(negedge clk);
        check("t6 PC_in refilled", 64'(pc_in), 64'h00400040);
        check("t6 rd_en_o full", 64'(rd_en_o), 64'h0);
        check("t6 empty refilled", 64'(empty), 64'h0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
